bcd_to_binary_seq: RTL

//  Sequential packed-BCD to unsigned binary converter; inverse of the combinational binary-to-BCD path.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_mac10.sv | 41 ++++
 rtl/bcd_to_binary_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks: digit width,
// largest legal decimal digit, and the converter state encoding.
package bcd_pkg;

    // One packed BCD digit is a nibble.
    localparam int DIGIT_W = 4;

    // Largest legal decimal digit; anything above is an illegal BCD code.
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    // Converter states. IDLE accepts an operand, CONV walks the digits,
    // DONE presents the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when a nibble is not a decimal digit (10..15).
    function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
        return (d > MAX_DIGIT);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step for decimal to binary
// conversion. The product is formed as (acc<<3)+(acc<<1) in a widened
// datapath so the overflow out of BIN_W bits is never lost, and the result
// saturates to all-ones whenever it does not fit.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 32
) (
    input  logic [BIN_W-1:0]   i_acc,
    input  logic [DIGIT_W-1:0] i_d,
    output logic [BIN_W-1:0]   o_next_acc,
    output logic               o_ovf,
    output logic               o_bad_digit
);

    // Four extra bits hold acc*10 + 15 without wrap-around.
    localparam int EXT_W = BIN_W + DIGIT_W;

    logic [EXT_W-1:0] w_acc_ext;
    logic [EXT_W-1:0] w_x8;
    logic [EXT_W-1:0] w_x2;
    logic [EXT_W-1:0] w_x10;
    logic [EXT_W-1:0] w_d_ext;
    logic [EXT_W-1:0] w_sum;

    // Shift-and-add product plus the incoming digit, then saturation.
    always_comb begin
        w_acc_ext   = {{DIGIT_W{1'b0}}, i_acc};
        w_x8        = w_acc_ext << 3;
        w_x2        = w_acc_ext << 1;
        w_x10       = w_x8 + w_x2;
        w_d_ext     = {{BIN_W{1'b0}}, i_d};
        w_sum       = w_x10 + w_d_ext;
        o_ovf       = |w_sum[EXT_W-1:BIN_W];
        o_next_acc  = o_ovf ? {BIN_W{1'b1}} : w_sum[BIN_W-1:0];
        // Illegal digits are flagged but still fed into the arithmetic.
        o_bad_digit = is_bad_digit(i_d);
    end

endmodule : bcd_mac10

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds data stable while valid is high and
// not yet accepted. in_ready depends only on state and rst_n, and out_valid
// is a register, so no combinational path exists from in_valid to any
// output or from out_ready to in_ready.
// Digits are consumed most significant first, one per clock, for exactly
// DIGITS cycles regardless of leading zeros. Error flags are sticky for the
// operand being converted and are cleared when the next operand is taken.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 10,
    parameter int BIN_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIN_W-1:0]            bin_out,
    output logic                        err_digit,
    output logic                        err_ovf,
    output logic                        busy
);

    localparam int OP_W  = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    // Count value while the last digit is being processed.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    // State and datapath registers.
    state_e             r_state;
    logic [OP_W-1:0]    r_shreg;
    logic [BIN_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_digit;
    logic               r_err_ovf;
    logic [BIN_W-1:0]   r_bin_out;
    logic               r_out_valid;

    // Per-cycle datapath values.
    logic [DIGIT_W-1:0] w_digit;
    logic [BIN_W-1:0]   w_next_acc;
    logic               w_step_ovf;
    logic               w_step_bad;
    logic               w_err_digit_nxt;
    logic               w_err_ovf_nxt;
    logic               w_last;
    logic               w_accept;
    logic               w_release;
    logic [BIN_W-1:0]   w_result;

    // The digit under conversion is always the top nibble of the shift
    // register; shifting left by one nibble exposes the next one.
    assign w_digit = r_shreg[OP_W-1 -: DIGIT_W];

    bcd_mac10 #(
        .BIN_W       (BIN_W)
    ) u_mac10 (
        .i_acc       (r_acc),
        .i_d         (w_digit),
        .o_next_acc  (w_next_acc),
        .o_ovf       (w_step_ovf),
        .o_bad_digit (w_step_bad)
    );

    // Handshake qualifiers and the final-result selection.
    always_comb begin
        w_accept        = in_valid && in_ready;
        w_release       = r_out_valid && out_ready;
        w_last          = (r_cnt == LAST_CNT);
        w_err_digit_nxt = r_err_digit || w_step_bad;
        w_err_ovf_nxt   = r_err_ovf || w_step_ovf;
        // An illegal digit makes the number meaningless, so it wins over
        // overflow and forces zero; overflow alone reports saturation.
        if (w_err_digit_nxt) begin
            w_result = '0;
        end else if (w_err_ovf_nxt) begin
            w_result = {BIN_W{1'b1}};
        end else begin
            w_result = w_next_acc;
        end
    end

    // Converter FSM with shift register, digit counter, flags and the
    // registered result; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err_digit <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_bin_out   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg     <= bcd_in;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_err_digit <= 1'b0;
                        r_err_ovf   <= 1'b0;
                        r_state     <= CONV;
                    end
                end
                CONV: begin
                    r_acc       <= w_next_acc;
                    r_shreg     <= r_shreg << DIGIT_W;
                    r_cnt       <= r_cnt + 1'b1;
                    r_err_digit <= w_err_digit_nxt;
                    r_err_ovf   <= w_err_ovf_nxt;
                    if (w_last) begin
                        r_bin_out   <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Ready is withheld while reset is asserted even though the state is
    // about to become IDLE, so nothing can be taken during reset.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign err_digit = r_err_digit;
    assign err_ovf   = r_err_ovf;

    // Structural invariants: a result is only presented from DONE, and the
    // digit counter never runs past the last digit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!r_out_valid || (r_state == DONE))
                else $error("out_valid outside DONE");
            assert ((r_state != DONE) || r_out_valid)
                else $error("DONE without out_valid");
            assert ((r_state != CONV) || (r_cnt <= LAST_CNT))
                else $error("digit counter overrun");
        end
    end

endmodule : bcd_to_binary_seq
